// File: rtl/vote_tally_n_if.sv
// vote_tally_n_if: board pin bundle for the vote tally unit
//   KEY, KEY_START, KEY_STOP   active-low keys (driven by master)
//   LED_VOTE, LED_PASS, LED_FAIL, SEG_EN, SEG_DATA   board outputs (driven by slave)
interface vote_tally_n_if #(parameter int N_VOTERS = 8);
    logic [N_VOTERS-1:0] KEY;
    logic                KEY_START;
    logic                KEY_STOP;
    logic [N_VOTERS-1:0] LED_VOTE;
    logic                LED_PASS;
    logic                LED_FAIL;
    logic [5:0]          SEG_EN;
    logic [6:0]          SEG_DATA;
    modport master (output KEY, KEY_START, KEY_STOP,
                    input  LED_VOTE, LED_PASS, LED_FAIL, SEG_EN, SEG_DATA);
    modport slave  (input  KEY, KEY_START, KEY_STOP,
                    output LED_VOTE, LED_PASS, LED_FAIL, SEG_EN, SEG_DATA);
endinterface

// File: rtl/vote_tally_n.sv
// vote_tally_n: N-voter session voting unit with debounced keys, 2-digit 7-seg count and pass/fail LEDs
//   CLK_50M  system clock
//   RST_N    async active-low reset
//   pins     vote_tally_n_if.slave: keys in (active-low), vote/pass/fail LEDs, SEG_EN (active-low), SEG_DATA
//   Optional: define VOTE_TIMEOUT_EN to close voting automatically after TIMEOUT_CYCLES.
module vote_tally_n #(
    parameter int N_VOTERS       = 8,
    parameter int THRESHOLD      = N_VOTERS / 2 + 1,
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int SCAN_CYCLES    = 50_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input logic           CLK_50M,
    input logic           RST_N,
    vote_tally_n_if.slave pins
);
    localparam int NK = N_VOTERS + 2;
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [3:0] TH = 4'(THRESHOLD);
    localparam logic [6:0] SEG [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                        7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

    typedef enum logic [1:0] {IDLE, VOTING, RESULT} state_t;
    state_t state, state_n;

    logic [NK-1:0]       raw, s1, s2, cond, press;
    logic [N_VOTERS-1:0] votes, votes_n;
    logic [3:0]          count, pc, units;
    logic                tens, start, stop, timeout, digit, led_pass, led_fail;
    logic [SW-1:0]       scan;
    logic [5:0]          seg_en;
    logic [6:0]          seg_data;

    assign raw = {pins.KEY_STOP, pins.KEY_START, pins.KEY};

    // Synchronisers start at "pressed" so nothing is trusted until a real release is seen.
    always_ff @(posedge CLK_50M or negedge RST_N)
        if (!RST_N) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end

    // Each key stays unarmed until it has been seen released for DEB_CYCLES; only then
    // does it debounce normally, so a key held through reset never yields a press.
    for (genvar k = 0; k < NK; k++) begin : g_deb
        logic          deb, armed;
        logic [CW-1:0] cnt;
        assign cond[k]  = armed ? s2[k] != deb : s2[k];
        assign press[k] = armed & cond[k] & ~s2[k] & (cnt == DEB_LAST);
        always_ff @(posedge CLK_50M or negedge RST_N)
            if (!RST_N) begin
                deb   <= 1'b1;
                armed <= 1'b0;
                cnt   <= '0;
            end else if (!cond[k]) cnt <= '0;
            else if (cnt == DEB_LAST) begin
                cnt   <= '0;
                armed <= 1'b1;
                if (armed) deb <= s2[k];
            end else cnt <= cnt + CW'(1);
    end

    assign start = press[N_VOTERS];
    assign stop  = press[N_VOTERS+1];

`ifdef VOTE_TIMEOUT_EN
    logic [31:0] tcnt;
    always_ff @(posedge CLK_50M or negedge RST_N)
        if (!RST_N) tcnt <= '0;
        else tcnt <= (state != VOTING || start) ? '0 : tcnt + 32'd1;
    assign timeout = state == VOTING && tcnt == 32'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // START is checked first everywhere: it beats STOP and discards same-cycle voter presses.
    always_comb begin
        state_n = state;
        votes_n = votes;
        case (state)
            IDLE: begin
                votes_n = '0;
                if (start) state_n = VOTING;
            end
            VOTING:
                if (start) votes_n = '0;
                else begin
                    votes_n = votes | press[N_VOTERS-1:0];
                    if (stop || timeout) state_n = RESULT;
                end
            RESULT:
                if (start) begin
                    votes_n = '0;
                    state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < N_VOTERS; i++) pc = pc + 4'(votes[i]);
    end

    assign tens  = count >= 4'd10;
    assign units = tens ? count - 4'd10 : count;

    // Result LEDs use the live popcount so a vote latched with STOP is already included.
    always_ff @(posedge CLK_50M or negedge RST_N)
        if (!RST_N) begin
            state    <= IDLE;
            votes    <= '0;
            count    <= '0;
            led_pass <= 1'b0;
            led_fail <= 1'b0;
            scan     <= '0;
            digit    <= 1'b0;
            seg_en   <= '1;
            seg_data <= '0;
        end else begin
            state    <= state_n;
            votes    <= votes_n;
            count    <= pc;
            led_pass <= state == RESULT && pc >= TH;
            led_fail <= state == RESULT && pc < TH;
            scan     <= scan == SCAN_LAST ? '0 : scan + SW'(1);
            digit    <= digit ^ (scan == SCAN_LAST);
            seg_en   <= digit ? 6'b101111 : 6'b011111;
            seg_data <= SEG[digit ? {3'b000, tens} : units];
        end

    assign pins.LED_VOTE = votes;
    assign pins.LED_PASS = led_pass;
    assign pins.LED_FAIL = led_fail;
    assign pins.SEG_EN   = seg_en;
    assign pins.SEG_DATA = seg_data;
endmodule

// File: tb/tb_vote_tally_n.sv
// tb_vote_tally_n: directed vector bench for vote_tally_n
module tb_vote_tally_n;
    localparam logic [9:0] START = 10'h100;
    localparam logic [9:0] STOP  = 10'h200;

    typedef struct {
        logic [9:0] mask;
        logic [7:0] vote;
        logic       pass;
        logic       fail;
        logic [6:0] units;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] keys_n = '1;
    int         checks = 0;
    int         errors = 0;
    vec_t       tab [36];
    logic [6:0] u, t;

    vote_tally_n_if #(.N_VOTERS(8)) pins ();
    assign pins.KEY       = keys_n[7:0];
    assign pins.KEY_START = keys_n[8];
    assign pins.KEY_STOP  = keys_n[9];

    vote_tally_n #(
        .N_VOTERS(8), .THRESHOLD(5), .DEB_CYCLES(4), .SCAN_CYCLES(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK_50M(clk),
        .RST_N(rst_n),
        .pins(pins)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [9:0] mask);
        keys_n = ~mask;
        tick(10);
        keys_n = '1;
        tick(10);
    endtask

    task automatic read_digits(output logic [6:0] du, output logic [6:0] dt);
        du = 'x;
        dt = 'x;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (pins.SEG_EN == 6'b011111) du = pins.SEG_DATA;
            if (pins.SEG_EN == 6'b101111) dt = pins.SEG_DATA;
        end
    endtask

    initial begin
        tab[0]  = '{10'h001, 8'h00, 1'b0, 1'b0, 7'h3f};
        tab[1]  = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[2]  = '{10'h001, 8'h01, 1'b0, 1'b0, 7'h06};
        tab[3]  = '{10'h004, 8'h05, 1'b0, 1'b0, 7'h5b};
        tab[4]  = '{10'h010, 8'h15, 1'b0, 1'b0, 7'h4f};
        tab[5]  = '{10'h040, 8'h55, 1'b0, 1'b0, 7'h66};
        tab[6]  = '{10'h080, 8'hD5, 1'b0, 1'b0, 7'h6d};
        tab[7]  = '{10'h080, 8'hD5, 1'b0, 1'b0, 7'h6d};
        tab[8]  = '{STOP,    8'hD5, 1'b1, 1'b0, 7'h6d};
        tab[9]  = '{10'h002, 8'hD5, 1'b1, 1'b0, 7'h6d};
        tab[10] = '{STOP,    8'hD5, 1'b1, 1'b0, 7'h6d};
        tab[11] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[12] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[13] = '{10'h008, 8'h08, 1'b0, 1'b0, 7'h06};
        tab[14] = '{10'h008, 8'h08, 1'b0, 1'b0, 7'h06};
        tab[15] = '{10'h008, 8'h08, 1'b0, 1'b0, 7'h06};
        tab[16] = '{STOP,    8'h08, 1'b0, 1'b1, 7'h06};
        tab[17] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[18] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[19] = '{10'h001, 8'h01, 1'b0, 1'b0, 7'h06};
        tab[20] = '{10'h3FF, 8'h00, 1'b0, 1'b0, 7'h3f};
        tab[21] = '{10'h020, 8'h20, 1'b0, 1'b0, 7'h06};
        tab[22] = '{10'h202, 8'h22, 1'b0, 1'b1, 7'h5b};
        tab[23] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[24] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[25] = '{10'h00F, 8'h0F, 1'b0, 1'b0, 7'h66};
        tab[26] = '{STOP,    8'h0F, 1'b0, 1'b1, 7'h66};
        tab[27] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[28] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[29] = '{10'h21F, 8'h1F, 1'b1, 1'b0, 7'h6d};
        tab[30] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[31] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};
        tab[32] = '{10'h0FF, 8'hFF, 1'b0, 1'b0, 7'h7f};
        tab[33] = '{STOP,    8'hFF, 1'b1, 1'b0, 7'h7f};
        tab[34] = '{10'h010, 8'hFF, 1'b1, 1'b0, 7'h7f};
        tab[35] = '{START,   8'h00, 1'b0, 1'b0, 7'h3f};

        tick(3);
        check("rst seg_en", pins.SEG_EN, 6'b111111);
        check("rst seg_data", pins.SEG_DATA, 7'h00);
        check("rst led_vote", pins.LED_VOTE, 8'h00);
        check("rst led_pass", pins.LED_PASS, 1'b0);
        check("rst led_fail", pins.LED_FAIL, 1'b0);

        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check($sformatf("scan%0d seg_en", k), pins.SEG_EN, ((k / 2) % 2) != 0 ? 6'b101111 : 6'b011111);
            check($sformatf("scan%0d seg_data", k), pins.SEG_DATA, 7'h3f);
        end
        check("idle led_pass", pins.LED_PASS, 1'b0);
        check("idle led_fail", pins.LED_FAIL, 1'b0);
        tick(10);

        for (int i = 0; i < 36; i++) begin
            press(tab[i].mask);
            check($sformatf("vec%0d led_vote", i), pins.LED_VOTE, tab[i].vote);
            check($sformatf("vec%0d led_pass", i), pins.LED_PASS, tab[i].pass);
            check($sformatf("vec%0d led_fail", i), pins.LED_FAIL, tab[i].fail);
            read_digits(u, t);
            check($sformatf("vec%0d units", i), u, tab[i].units);
            check($sformatf("vec%0d tens", i), t, 7'h3f);
        end

        keys_n[8] = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        keys_n[8] = 1'b1;
        tick(10);
        press(10'h001);
        check("held start ignored", pins.LED_VOTE, 8'h00);
        press(START);
        press(10'h001);
        check("start after release", pins.LED_VOTE, 8'h01);

        keys_n[1] = 1'b0;
        tick(3);
        keys_n[1] = 1'b1;
        tick(12);
        check("glitch 3clk", pins.LED_VOTE, 8'h01);
        keys_n[1] = 1'b0;
        tick(6);
        keys_n[1] = 1'b1;
        tick(12);
        check("press 6clk", pins.LED_VOTE, 8'h03);

        #2 rst_n = 1'b0;
        #1 check("async rst led_vote", pins.LED_VOTE, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        press(10'h004);
        check("rst back to idle", pins.LED_VOTE, 8'h00);

        press(START);
        press(10'h001);
        press(10'h002);
        check("pre-timeout led_vote", pins.LED_VOTE, 8'h03);
        check("pre-timeout led_fail", pins.LED_FAIL, 1'b0);
`ifdef VOTE_TIMEOUT_EN
        tick(70);
        check("timeout led_fail", pins.LED_FAIL, 1'b1);
        check("timeout led_pass", pins.LED_PASS, 1'b0);
        press(10'h004);
        check("timeout frozen", pins.LED_VOTE, 8'h03);
`else
        tick(150);
        check("no timeout led_fail", pins.LED_FAIL, 1'b0);
        press(10'h004);
        check("still voting", pins.LED_VOTE, 8'h07);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
